// File: rtl/rr_log_packet_scheduler_if.sv
// Logging-bus and packet-stream interfaces for the log packet scheduler.
// The recorder side is the bus master; the log-storage sink is the stream slave.
interface rr_log_bus_if #(
  parameter int NUM_CH = 5,
  parameter int CH_W   = 64
);
  logic [NUM_CH-1:0]      logb_valid;
  logic [NUM_CH*CH_W-1:0] logb_data;
  logic [NUM_CH-1:0]      loge_valid;
  logic                   logb_almful;

  modport master (output logb_valid, logb_data, loge_valid, input logb_almful);
  modport slave  (input logb_valid, logb_data, loge_valid, output logb_almful);
endinterface

interface rr_log_out_if #(
  parameter int OUT_W = 64
);
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;

  modport master (output out_valid, out_data, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_last, output out_ready);
endinterface

// File: rtl/rr_log_packet_scheduler.sv
// Snapshots logging-bus activity into a FIFO and emits each snapshot as header + per-channel beats.
// Header visible the cycle after push; outputs hold under backpressure; logb_almful throttles recorders.
module rr_log_packet_scheduler #(
  parameter int NUM_CH        = 5,
  parameter int CH_W          = 64,
  parameter int OUT_W         = 64,
  parameter int DEPTH         = 16,
  parameter int ALMFUL_MARGIN = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  rr_log_bus_if.slave              log_bus,
  rr_log_out_if.master             log_out,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int ENT_W = 2*NUM_CH + NUM_CH*CH_W;

  if (OUT_W < CH_W) begin : g_chk_out_ch
    $error("OUT_W must be >= CH_W");
  end
  if (OUT_W < 2*NUM_CH) begin : g_chk_out_hdr
    $error("OUT_W must be >= 2*NUM_CH");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("DEPTH must be a power of 2");
  end
  if (ALMFUL_MARGIN >= DEPTH) begin : g_chk_margin
    $error("ALMFUL_MARGIN must be < DEPTH");
  end

  typedef enum logic {S_HDR, S_DATA} state_t;

  logic [ENT_W-1:0]       mem [DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count, count_nxt;
  state_t                 state, state_nxt;
  logic [NUM_CH-1:0]      rem_mask, rem_mask_nxt;
  logic [NUM_CH-1:0]      head_logb, head_loge;
  logic [NUM_CH*CH_W-1:0] head_data;
  logic [CH_W-1:0]        sel_payload;
  logic                   empty, full, push_req, push_acc, pop, hs;
  logic                   data_last, almful_q;

  assign {head_loge, head_logb, head_data} = mem[rd_ptr];

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign push_req  = (|log_bus.logb_valid) || (|log_bus.loge_valid);
  assign hs        = !empty && log_out.out_ready;
  assign data_last = ((rem_mask & (rem_mask - 1'b1)) == '0);
  assign pop       = hs && log_out.out_last;
  // A full FIFO still takes the new snapshot when the head retires on the same edge.
  assign push_acc  = push_req && (!full || pop);
  assign count_nxt = count + (AW+1)'(push_acc) - (AW+1)'(pop);

  assign occupancy           = count;
  assign log_out.out_valid   = !empty;
  assign log_bus.logb_almful = almful_q;

  always_comb begin
    state_nxt        = state;
    rem_mask_nxt     = rem_mask;
    log_out.out_data = '0;
    log_out.out_last = 1'b0;
    sel_payload      = '0;
    // Descending scan so the lowest remaining channel wins.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rem_mask[i]) sel_payload = head_data[i*CH_W +: CH_W];
    end
    case (state)
      S_HDR: begin
        log_out.out_data[2*NUM_CH-1:0] = {head_loge, head_logb};
        log_out.out_last               = (head_logb == '0);
        if (hs && head_logb != '0) begin
          rem_mask_nxt = head_logb;
          state_nxt    = S_DATA;
        end
      end
      S_DATA: begin
        log_out.out_data[CH_W-1:0] = sel_payload;
        log_out.out_last           = data_last;
        if (hs) begin
          rem_mask_nxt = rem_mask & (rem_mask - 1'b1);
          if (data_last) state_nxt = S_HDR;
        end
      end
      default: state_nxt = S_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= S_HDR;
      rem_mask <= '0;
      almful_q <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      rem_mask <= rem_mask_nxt;
      count    <= count_nxt;
      almful_q <= (count_nxt >= (AW+1)'(DEPTH - ALMFUL_MARGIN));
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      if (push_req && !push_acc) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= {log_bus.loge_valid, log_bus.logb_valid, log_bus.logb_data};
  end

endmodule

// File: tb/tb_rr_log_packet_scheduler.sv
// Bench for rr_log_packet_scheduler: vector table, directed corner sequences, randomized run vs queue model.
module tb_rr_log_packet_scheduler;
  localparam int NUM_CH = 5;
  localparam int CH_W   = 64;
  localparam int OUT_W  = 64;
  localparam int DEPTH  = 16;
  localparam int MARGIN = 4;
  localparam int DW     = NUM_CH * CH_W;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [$clog2(DEPTH):0] occupancy;
  logic                   overflow;

  rr_log_bus_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) lb ();
  rr_log_out_if #(.OUT_W(OUT_W)) ob ();

  rr_log_packet_scheduler #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .ALMFUL_MARGIN(MARGIN)
  ) dut (
    .clk(clk), .rstn(rstn), .log_bus(lb), .log_out(ob),
    .occupancy(occupancy), .overflow(overflow)
  );

  typedef struct packed {
    logic [4:0]       logb;
    logic [4:0]       loge;
    logic [DW-1:0]    d;
    logic [2:0]       n;
    logic [5:0][63:0] beat;
  } vec_t;

  typedef struct packed {
    logic [4:0]    logb;
    logic [4:0]    loge;
    logic [DW-1:0] d;
  } snap_t;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic [4:0] logb, input logic [4:0] loge,
                       input logic [DW-1:0] d, input logic rdy);
    lb.logb_valid = logb;
    lb.loge_valid = loge;
    lb.logb_data  = d;
    ob.out_ready  = rdy;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    drive(5'd0, 5'd0, '0, 1'b0);
    rstn = 1'b0;
    tick;
    tick;
    @(negedge clk);
    rstn = 1'b1;
    tick;
  endtask

  function automatic logic [DW-1:0] pay(input int ch, input logic [63:0] v);
    logic [DW-1:0] r;
    r = '0;
    r[ch*CH_W +: CH_W] = v;
    return r;
  endfunction

  // Beat p of a snapshot: 0 is the header, p>0 is the p-th logged channel in ascending order.
  function automatic logic [63:0] exp_beat(input snap_t s, input int p);
    int k;
    k = 0;
    if (p == 0) return 64'({s.loge, s.logb});
    for (int i = 0; i < NUM_CH; i++) begin
      if (s.logb[i]) begin
        k++;
        if (k == p) return s.d[i*CH_W +: CH_W];
      end
    end
    return '0;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want run completion");
    $fatal(1);
  end

  vec_t  vt [5];
  snap_t q [$];
  int    pos;
  bit    m_ovf;

  initial begin
    vt[0] = '0; vt[0].logb = 5'h01; vt[0].loge = 5'h01; vt[0].d = pay(0, 64'hA);
    vt[0].n = 3'd2; vt[0].beat[0] = 64'h21; vt[0].beat[1] = 64'hA;
    vt[1] = '0; vt[1].logb = 5'h00; vt[1].loge = 5'h10;
    vt[1].n = 3'd1; vt[1].beat[0] = 64'h200;
    vt[2] = '0; vt[2].logb = 5'h14; vt[2].loge = 5'h00; vt[2].d = pay(2, 64'h22) | pay(4, 64'h44);
    vt[2].n = 3'd3; vt[2].beat[0] = 64'h14; vt[2].beat[1] = 64'h22; vt[2].beat[2] = 64'h44;
    vt[3] = '0; vt[3].logb = 5'h0A; vt[3].loge = 5'h02;
    vt[3].d = pay(0, 64'h55) | pay(1, 64'hDEADBEEF_01234567) | pay(3, 64'hFFFF_FFFF_FFFF_FFFF);
    vt[3].n = 3'd3; vt[3].beat[0] = 64'h4A; vt[3].beat[1] = 64'hDEADBEEF_01234567;
    vt[3].beat[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    vt[4] = '0; vt[4].logb = 5'h1F; vt[4].loge = 5'h1F; vt[4].n = 3'd6; vt[4].beat[0] = 64'h3FF;
    for (int i = 0; i < NUM_CH; i++) begin
      vt[4].d[i*CH_W +: CH_W] = 64'h100 + 64'(i);
      vt[4].beat[i+1]         = 64'h100 + 64'(i);
    end

    do_reset;
    check("rst_valid", ob.out_valid, 1'b0);
    check("rst_occ", occupancy, 0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_almful", lb.logb_almful, 1'b0);

    for (int v = 0; v < 5; v++) begin
      drive(vt[v].logb, vt[v].loge, vt[v].d, 1'b1);
      tick;
      drive(5'd0, 5'd0, '0, 1'b1);
      for (int j = 0; j < int'(vt[v].n); j++) begin
        check($sformatf("vec%0d_valid%0d", v, j), ob.out_valid, 1'b1);
        check($sformatf("vec%0d_data%0d", v, j), ob.out_data, vt[v].beat[j]);
        check($sformatf("vec%0d_last%0d", v, j), ob.out_last, (j == int'(vt[v].n) - 1));
        tick;
      end
      check($sformatf("vec%0d_occ_end", v), occupancy, 0);
      check($sformatf("vec%0d_idle", v), ob.out_valid, 1'b0);
    end

    // Stalled sink, one push per cycle: threshold, stability and drop.
    do_reset;
    for (int i = 1; i <= 17; i++) begin
      drive(5'h01, 5'h00, pay(0, 64'(i)), 1'b0);
      tick;
      check($sformatf("fill_occ%0d", i), occupancy, (i > DEPTH) ? DEPTH : i);
      check($sformatf("fill_almful%0d", i), lb.logb_almful, (i >= DEPTH - MARGIN));
      check($sformatf("fill_ovf%0d", i), overflow, (i > DEPTH));
      check($sformatf("fill_data%0d", i), ob.out_data, 64'h01);
      check($sformatf("fill_last%0d", i), ob.out_last, 1'b0);
    end

    // Full FIFO: last beat of head retires on the same edge as a new push.
    do_reset;
    for (int i = 0; i < DEPTH; i++) begin
      drive(5'h01, 5'h00, pay(0, 64'h500 + 64'(i)), 1'b0);
      tick;
    end
    drive(5'd0, 5'd0, '0, 1'b0);
    check("full_occ", occupancy, DEPTH);
    check("full_ovf", overflow, 1'b0);
    drive(5'd0, 5'd0, '0, 1'b1);
    tick;
    check("full_pay", ob.out_data, 64'h500);
    check("full_pay_last", ob.out_last, 1'b1);
    drive(5'h01, 5'h00, pay(0, 64'h5AA), 1'b1);
    tick;
    drive(5'd0, 5'd0, '0, 1'b1);
    check("pp_occ", occupancy, DEPTH);
    check("pp_ovf", overflow, 1'b0);
    check("pp_next_hdr", ob.out_data, 64'h01);
    for (int i = 1; i <= DEPTH; i++) begin
      check($sformatf("drain_hdr%0d", i), ob.out_data, 64'h01);
      check($sformatf("drain_hdr_last%0d", i), ob.out_last, 1'b0);
      tick;
      check($sformatf("drain_pay%0d", i), ob.out_data, (i == DEPTH) ? 64'h5AA : 64'h500 + 64'(i));
      check($sformatf("drain_pay_last%0d", i), ob.out_last, 1'b1);
      tick;
    end
    check("drain_occ", occupancy, 0);
    check("drain_ovf", overflow, 1'b0);

    // Reset after header accepted, before any payload beat completes.
    do_reset;
    drive(5'h03, 5'h00, pay(0, 64'h11) | pay(1, 64'h12), 1'b1);
    tick;
    drive(5'd0, 5'd0, '0, 1'b1);
    check("mid_hdr", ob.out_data, 64'h03);
    tick;
    check("mid_pay0", ob.out_data, 64'h11);
    check("mid_pay0_last", ob.out_last, 1'b0);
    drive(5'd0, 5'd0, '0, 1'b0);
    rstn = 1'b0;
    #1;
    check("mid_rst_valid", ob.out_valid, 1'b0);
    check("mid_rst_occ", occupancy, 0);
    @(negedge clk);
    rstn = 1'b1;
    drive(5'h04, 5'h04, pay(2, 64'h77), 1'b1);
    tick;
    drive(5'd0, 5'd0, '0, 1'b1);
    check("post_rst_hdr", ob.out_data, 64'h84);
    check("post_rst_hdr_last", ob.out_last, 1'b0);
    tick;
    check("post_rst_pay", ob.out_data, 64'h77);
    check("post_rst_pay_last", ob.out_last, 1'b1);
    tick;
    check("post_rst_idle", ob.out_valid, 1'b0);

    // Randomized traffic against a snapshot-queue model.
    do_reset;
    q.delete();
    pos   = 0;
    m_ovf = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      logic [4:0]    rb, re;
      logic [DW-1:0] rd;
      logic          rr;
      int            push_pct, rdy_pct;
      push_pct = ((c / 400) % 2 == 0) ? 70 : 30;
      rdy_pct  = ((c / 400) % 2 == 0) ? 40 : 85;
      rb = '0;
      re = '0;
      if ($urandom_range(99) < push_pct) begin
        rb = 5'($urandom);
        re = 5'($urandom);
      end
      for (int i = 0; i < NUM_CH; i++) rd[i*CH_W +: CH_W] = {$urandom, $urandom};
      rr = ($urandom_range(99) < rdy_pct);
      drive(rb, re, rd, rr);
      tick;
      if (q.size() > 0 && rr) begin
        if (pos == $countones(q[0].logb)) begin
          void'(q.pop_front());
          pos = 0;
        end else begin
          pos++;
        end
      end
      if (rb != 0 || re != 0) begin
        if (q.size() < DEPTH) q.push_back({rb, re, rd});
        else m_ovf = 1'b1;
      end
      check("rnd_valid", ob.out_valid, (q.size() > 0));
      check("rnd_occ", occupancy, q.size());
      check("rnd_ovf", overflow, m_ovf);
      check("rnd_almful", lb.logb_almful, (q.size() >= DEPTH - MARGIN));
      if (q.size() > 0) begin
        check("rnd_data", ob.out_data, exp_beat(q[0], pos));
        check("rnd_last", ob.out_last, (pos == $countones(q[0].logb)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
